// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared constants for the MIPS pipeline: ALU select codes,
//               default datapath/register-address widths, the zero register
//               index and a helper that maps any select onto the legal set.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int DEFAULT_DW = 32;
  localparam int DEFAULT_AW = 5;
  localparam int REG_ZERO   = 0;

  localparam logic [3:0] ALU_AND  = 4'b1110;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_MUL  = 4'b0011;
  localparam logic [3:0] ALU_PASS = 4'b1100;

  // Undefined select codes fall back to ADD so the ALU only ever sees a legal code.
  function automatic logic [3:0] alu_sel_legal(input logic [3:0] sel);
    logic [3:0] res;
    case (sel)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MUL, ALU_PASS: res = sel;
      default: res = ALU_ADD;
    endcase
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_mux.sv
`default_nettype none
// ============================================================================
// Module      : fwd_mux
// Description : Per-operand two-source forwarding selector. The younger
//               EX/MEM result beats the older MEM/WB result; register 0 is
//               never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_mux
  import mips_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic [AW-1:0] i_src_addr,
  input  logic [DW-1:0] i_reg_data,
  input  logic          i_exm_we,
  input  logic [AW-1:0] i_exm_addr,
  input  logic [DW-1:0] i_exm_data,
  input  logic          i_wb_we,
  input  logic [AW-1:0] i_wb_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic [DW-1:0] o_data
);

  logic w_src_nz;
  logic w_exm_hit;
  logic w_wb_hit;

  assign w_src_nz  = (i_src_addr != AW'(REG_ZERO));
  assign w_exm_hit = i_exm_we && (i_exm_addr == i_src_addr) && w_src_nz;
  assign w_wb_hit  = i_wb_we  && (i_wb_addr  == i_src_addr) && w_src_nz;

  // Youngest producer wins; otherwise use the value read from the register file.
  always_comb begin
    o_data = i_reg_data;
    if (w_exm_hit)
      o_data = i_exm_data;
    else if (w_wb_hit)
      o_data = i_wb_data;
  end

endmodule
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_stage
// Description : ID/EX pipeline register feeding the ALU. Captures decoded
//               operands and control, forwards from EX/MEM and MEM/WB, and
//               raises the load-use stall toward fetch/decode.
//               Build option FORWARDING_EN: when defined, operands are
//               forwarded; when undefined, operands come straight from the
//               captured register data and the stall also covers pending
//               EX/MEM and MEM/WB writes to a decode source register.
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DW = DEFAULT_DW,
  parameter int AW = DEFAULT_AW
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_stall,
  input  logic          i_flush,
  input  logic          i_valid,
  input  logic [DW-1:0] i_rs_data,
  input  logic [DW-1:0] i_rt_data,
  input  logic [DW-1:0] i_imm,
  input  logic [AW-1:0] i_rs_addr,
  input  logic [AW-1:0] i_rt_addr,
  input  logic [AW-1:0] i_rd_addr,
  input  logic          i_uses_rt,
  input  logic [3:0]    i_alu_sel,
  input  logic          i_alu_src,
  input  logic          i_reg_dst,
  input  logic          i_reg_write,
  input  logic          i_mem_read,
  input  logic          i_mem_write,
  input  logic          i_mem_to_reg,
  input  logic          i_exm_reg_write,
  input  logic [AW-1:0] i_exm_wr_addr,
  input  logic [DW-1:0] i_exm_data,
  input  logic          i_wb_reg_write,
  input  logic [AW-1:0] i_wb_wr_addr,
  input  logic [DW-1:0] i_wb_data,
  output logic          o_valid,
  output logic [DW-1:0] o_alu_op1,
  output logic [DW-1:0] o_alu_op2,
  output logic [3:0]    o_alu_sel,
  output logic [DW-1:0] o_store_data,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_reg_write,
  output logic          o_mem_read,
  output logic          o_mem_write,
  output logic          o_mem_to_reg,
  output logic          o_load_use_stall
);

  logic          r_valid;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [AW-1:0] r_rs_addr;
  logic [AW-1:0] r_rt_addr;
  logic [AW-1:0] r_wr_addr;
  logic [3:0]    r_alu_sel;
  logic          r_alu_src;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;
  logic          r_mem_to_reg;

  logic          w_bubble;
  logic          w_exm_fwd_en;
  logic          w_wb_fwd_en;
  logic          w_hazard_stall;
  logic          w_load_use;
  logic [DW-1:0] w_fwd_a;
  logic [DW-1:0] w_fwd_b;

  // A flush, or an empty decode slot on a non-stalled cycle, inserts a bubble.
  assign w_bubble = i_flush || (!i_stall && !i_valid);

  // Pipeline register: reset > flush > stall > load.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_wr_addr    <= '0;
      r_alu_sel    <= ALU_ADD;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (w_bubble) begin
      r_valid      <= 1'b0;
      r_rs_data    <= '0;
      r_rt_data    <= '0;
      r_imm        <= '0;
      r_rs_addr    <= '0;
      r_rt_addr    <= '0;
      r_wr_addr    <= '0;
      r_alu_sel    <= ALU_ADD;
      r_alu_src    <= 1'b0;
      r_reg_write  <= 1'b0;
      r_mem_read   <= 1'b0;
      r_mem_write  <= 1'b0;
      r_mem_to_reg <= 1'b0;
    end else if (!i_stall) begin
      r_valid      <= 1'b1;
      r_rs_data    <= i_rs_data;
      r_rt_data    <= i_rt_data;
      r_imm        <= i_imm;
      r_rs_addr    <= i_rs_addr;
      r_rt_addr    <= i_rt_addr;
      r_wr_addr    <= i_reg_dst ? i_rd_addr : i_rt_addr;
      r_alu_sel    <= alu_sel_legal(i_alu_sel);
      r_alu_src    <= i_alu_src;
      r_reg_write  <= i_reg_write;
      r_mem_read   <= i_mem_read;
      r_mem_write  <= i_mem_write;
      r_mem_to_reg <= i_mem_to_reg;
    end
  end

`ifdef FORWARDING_EN
  assign w_exm_fwd_en   = i_exm_reg_write;
  assign w_wb_fwd_en    = i_wb_reg_write;
  assign w_hazard_stall = 1'b0;
`else
  // True when a nonzero destination matches a source the decode slot reads.
  function automatic logic dec_reads(input logic [AW-1:0] dst,
                                     input logic [AW-1:0] rs,
                                     input logic [AW-1:0] rt,
                                     input logic          uses_rt);
    return (dst != AW'(REG_ZERO)) && ((dst == rs) || (uses_rt && (dst == rt)));
  endfunction

  // Without forwarding, any in-flight write to a decode source must stall decode.
  assign w_exm_fwd_en   = 1'b0;
  assign w_wb_fwd_en    = 1'b0;
  assign w_hazard_stall = i_valid &&
      ((i_exm_reg_write && dec_reads(i_exm_wr_addr, i_rs_addr, i_rt_addr, i_uses_rt)) ||
       (i_wb_reg_write  && dec_reads(i_wb_wr_addr,  i_rs_addr, i_rt_addr, i_uses_rt)));
`endif

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_a (
    .i_src_addr (r_rs_addr),
    .i_reg_data (r_rs_data),
    .i_exm_we   (w_exm_fwd_en),
    .i_exm_addr (i_exm_wr_addr),
    .i_exm_data (i_exm_data),
    .i_wb_we    (w_wb_fwd_en),
    .i_wb_addr  (i_wb_wr_addr),
    .i_wb_data  (i_wb_data),
    .o_data     (w_fwd_a)
  );

  fwd_mux #(.DW(DW), .AW(AW)) u_fwd_b (
    .i_src_addr (r_rt_addr),
    .i_reg_data (r_rt_data),
    .i_exm_we   (w_exm_fwd_en),
    .i_exm_addr (i_exm_wr_addr),
    .i_exm_data (i_exm_data),
    .i_wb_we    (w_wb_fwd_en),
    .i_wb_addr  (i_wb_wr_addr),
    .i_wb_data  (i_wb_data),
    .o_data     (w_fwd_b)
  );

  // A load in EX whose destination feeds the instruction now in decode.
  assign w_load_use = r_valid && r_mem_read && (r_wr_addr != AW'(REG_ZERO)) && i_valid &&
                      ((r_wr_addr == i_rs_addr) || (i_uses_rt && (r_wr_addr == i_rt_addr)));

  assign o_valid          = r_valid;
  assign o_alu_op1        = w_fwd_a;
  assign o_alu_op2        = r_alu_src ? r_imm : w_fwd_b;
  assign o_alu_sel        = r_alu_sel;
  assign o_store_data     = w_fwd_b;
  assign o_wr_addr        = r_wr_addr;
  assign o_reg_write      = r_valid & r_reg_write;
  assign o_mem_read       = r_valid & r_mem_read;
  assign o_mem_write      = r_valid & r_mem_write;
  assign o_mem_to_reg     = r_valid & r_mem_to_reg;
  assign o_load_use_stall = w_load_use | w_hazard_stall;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_id_ex_stage
// Description : Scoreboard bench for id_ex_stage. Directed stimulus pushes
//               hand-computed expectations into a queue; a monitor on the
//               falling clock edge pops and compares them against the DUT.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_id_ex_stage;
  import mips_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  localparam int C_VALID = 0;
  localparam int C_OP1   = 1;
  localparam int C_OP2   = 2;
  localparam int C_STORE = 3;
  localparam int C_SEL   = 4;
  localparam int C_WR    = 5;
  localparam int C_RW    = 6;
  localparam int C_MR    = 7;
  localparam int C_MW    = 8;
  localparam int C_MTR   = 9;
  localparam int C_STALL = 10;

  logic          clk;
  logic          rst_n;
  logic          stall, flush, valid;
  logic [DW-1:0] rs_data, rt_data, imm;
  logic [AW-1:0] rs_addr, rt_addr, rd_addr;
  logic          uses_rt;
  logic [3:0]    alu_sel;
  logic          alu_src, reg_dst, reg_write, mem_read, mem_write, mem_to_reg;
  logic          exm_reg_write;
  logic [AW-1:0] exm_wr_addr;
  logic [DW-1:0] exm_data;
  logic          wb_reg_write;
  logic [AW-1:0] wb_wr_addr;
  logic [DW-1:0] wb_data;

  logic          o_valid;
  logic [DW-1:0] o_alu_op1, o_alu_op2, o_store_data;
  logic [3:0]    o_alu_sel;
  logic [AW-1:0] o_wr_addr;
  logic          o_reg_write, o_mem_read, o_mem_write, o_mem_to_reg, o_load_use_stall;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    string         name;
    logic [10:0]   chk;
    logic          valid;
    logic [DW-1:0] op1, op2, store;
    logic [3:0]    sel;
    logic [AW-1:0] wr;
    logic          rw, mr, mw, mtr, stall;
  } exp_t;

  exp_t sb[$];

  id_ex_stage #(.DW(DW), .AW(AW)) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_stall          (stall),
    .i_flush          (flush),
    .i_valid          (valid),
    .i_rs_data        (rs_data),
    .i_rt_data        (rt_data),
    .i_imm            (imm),
    .i_rs_addr        (rs_addr),
    .i_rt_addr        (rt_addr),
    .i_rd_addr        (rd_addr),
    .i_uses_rt        (uses_rt),
    .i_alu_sel        (alu_sel),
    .i_alu_src        (alu_src),
    .i_reg_dst        (reg_dst),
    .i_reg_write      (reg_write),
    .i_mem_read       (mem_read),
    .i_mem_write      (mem_write),
    .i_mem_to_reg     (mem_to_reg),
    .i_exm_reg_write  (exm_reg_write),
    .i_exm_wr_addr    (exm_wr_addr),
    .i_exm_data       (exm_data),
    .i_wb_reg_write   (wb_reg_write),
    .i_wb_wr_addr     (wb_wr_addr),
    .i_wb_data        (wb_data),
    .o_valid          (o_valid),
    .o_alu_op1        (o_alu_op1),
    .o_alu_op2        (o_alu_op2),
    .o_alu_sel        (o_alu_sel),
    .o_store_data     (o_store_data),
    .o_wr_addr        (o_wr_addr),
    .o_reg_write      (o_reg_write),
    .o_mem_read       (o_mem_read),
    .o_mem_write      (o_mem_write),
    .o_mem_to_reg     (o_mem_to_reg),
    .o_load_use_stall (o_load_use_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single field comparison; counts only when the expectation enables the field.
  task automatic cmp(input string n, input string f, input logic en,
                     input logic [31:0] act, input logic [31:0] exp);
    if (en) begin
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s.%s: got 0x%0h expected 0x%0h", n, f, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from capture.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      cmp(e.name, "valid", e.chk[C_VALID], 32'(o_valid),          32'(e.valid));
      cmp(e.name, "op1",   e.chk[C_OP1],   o_alu_op1,              e.op1);
      cmp(e.name, "op2",   e.chk[C_OP2],   o_alu_op2,              e.op2);
      cmp(e.name, "store", e.chk[C_STORE], o_store_data,           e.store);
      cmp(e.name, "sel",   e.chk[C_SEL],   32'(o_alu_sel),         32'(e.sel));
      cmp(e.name, "wr",    e.chk[C_WR],    32'(o_wr_addr),         32'(e.wr));
      cmp(e.name, "rw",    e.chk[C_RW],    32'(o_reg_write),       32'(e.rw));
      cmp(e.name, "mr",    e.chk[C_MR],    32'(o_mem_read),        32'(e.mr));
      cmp(e.name, "mw",    e.chk[C_MW],    32'(o_mem_write),       32'(e.mw));
      cmp(e.name, "mtr",   e.chk[C_MTR],   32'(o_mem_to_reg),      32'(e.mtr));
      cmp(e.name, "stall", e.chk[C_STALL], 32'(o_load_use_stall),  32'(e.stall));
    end
  end

  function automatic exp_t blank(input string n);
    exp_t e;
    e.name = n; e.chk = '0; e.valid = 1'b0; e.op1 = '0; e.op2 = '0; e.store = '0;
    e.sel = ALU_ADD; e.wr = '0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.mtr = 1'b0;
    e.stall = 1'b0;
    return e;
  endfunction

  task automatic push_full(input string n, input logic v, input logic [DW-1:0] a,
                           input logic [DW-1:0] b, input logic [DW-1:0] s,
                           input logic [3:0] sel, input logic [AW-1:0] wr,
                           input logic rw, input logic mr, input logic mw,
                           input logic mtr, input logic st);
    exp_t e;
    e = blank(n);
    e.chk = '1; e.valid = v; e.op1 = a; e.op2 = b; e.store = s; e.sel = sel; e.wr = wr;
    e.rw = rw; e.mr = mr; e.mw = mw; e.mtr = mtr; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic push_op1(input string n, input logic [DW-1:0] a);
    exp_t e;
    e = blank(n); e.chk[C_OP1] = 1'b1; e.op1 = a;
    sb.push_back(e);
  endtask

  task automatic push_op2st(input string n, input logic [DW-1:0] b, input logic [DW-1:0] s);
    exp_t e;
    e = blank(n); e.chk[C_OP2] = 1'b1; e.chk[C_STORE] = 1'b1; e.op2 = b; e.store = s;
    sb.push_back(e);
  endtask

  task automatic push_stall(input string n, input logic st);
    exp_t e;
    e = blank(n); e.chk[C_STALL] = 1'b1; e.stall = st;
    sb.push_back(e);
  endtask

  task automatic clr_inputs();
    stall = 0; flush = 0; valid = 0; rs_data = '0; rt_data = '0; imm = '0;
    rs_addr = '0; rt_addr = '0; rd_addr = '0; uses_rt = 0; alu_sel = ALU_ADD;
    alu_src = 0; reg_dst = 0; reg_write = 0; mem_read = 0; mem_write = 0; mem_to_reg = 0;
    exm_reg_write = 0; exm_wr_addr = '0; exm_data = '0;
    wb_reg_write = 0; wb_wr_addr = '0; wb_data = '0;
  endtask

  // Move to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    push_full("reset", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
    step();
    rst_n = 1'b1;

    // Basic capture, rt path then immediate path.
    valid = 1; rs_addr = 1; rt_addr = 2; rd_addr = 3; reg_dst = 1; rs_data = 5; rt_data = 7;
    alu_sel = ALU_SUB; alu_src = 0; reg_write = 1;
    step();
    push_full("capture_sub", 1, 5, 7, 7, ALU_SUB, 3, 1, 0, 0, 0, 0);
    alu_src = 1; imm = 32'hFFFF_FFFC; reg_dst = 0; alu_sel = ALU_ADD;
    step();
    push_full("capture_imm", 1, 5, 32'hFFFF_FFFC, 7, ALU_ADD, 2, 1, 0, 0, 0, 0);

    // Forwarding priority on rs = r3.
    rs_addr = 3; rs_data = 32'h99; rt_addr = 0; rt_data = 32'h44; alu_src = 0;
    alu_sel = ALU_OR; reg_write = 0;
    step();
    stall = 1; valid = 0;
    exm_reg_write = 1; exm_wr_addr = 3; exm_data = 32'h11;
    wb_reg_write = 1; wb_wr_addr = 3; wb_data = 32'h22;
    push_full("fwd_exm_prio", 1, FWD ? 32'h11 : 32'h99, 32'h44, 32'h44, ALU_OR, 0,
              0, 0, 0, 0, 0);
    step();
    exm_reg_write = 0;
    push_op1("fwd_wb", FWD ? 32'h22 : 32'h99);
    step();

    // Capture rs = r0, rt = r6; r0 writers must be ignored.
    stall = 0; valid = 1; rs_addr = 0; rs_data = 32'h55; rt_addr = 6; rt_data = 32'h66;
    alu_sel = ALU_AND; exm_reg_write = 1; exm_wr_addr = 0; wb_wr_addr = 0;
    step();
    stall = 1; valid = 0; wb_wr_addr = 6;
    push_full("fwd_r0_rt_wb", 1, 32'h55, FWD ? 32'h22 : 32'h66, FWD ? 32'h22 : 32'h66,
              ALU_AND, 6, 0, 0, 0, 0, 0);
    step();
    wb_wr_addr = 0;
    push_op1("fwd_r0_op1", 32'h55);
    push_op2st("fwd_r0_op2", 32'h66, 32'h66);
    step();

    // Load-use: lw r8 in EX.
    stall = 0; exm_reg_write = 0; wb_reg_write = 0; valid = 1; mem_read = 1; reg_write = 1;
    mem_to_reg = 1; reg_dst = 0; rt_addr = 8; rs_addr = 1; rs_data = 32'h100; rt_data = 0;
    imm = 4; alu_src = 1; alu_sel = ALU_ADD;
    step();
    stall = 1; rs_addr = 8; rt_addr = 2; uses_rt = 1;
    push_full("lw_rs_hit", 1, 32'h100, 4, 0, ALU_ADD, 8, 1, 1, 0, 1, 1);
    step();
    rs_addr = 2; rt_addr = 8; uses_rt = 0;
    push_stall("lw_rt_unused", 0);
    step();
    uses_rt = 1;
    push_stall("lw_rt_used", 1);
    step();
    stall = 0; rs_addr = 0; rt_addr = 0;
    push_stall("lw_no_src_match", 0);
    step();
    stall = 1;
    push_full("lw_dest_r0", 1, 32'h100, 4, 0, ALU_ADD, 0, 1, 1, 0, 1, 0);
    step();

    // Store capture, then hold under stall while inputs move.
    stall = 0; mem_read = 0; mem_to_reg = 0; reg_write = 0; mem_write = 1;
    rs_addr = 9; rs_data = 32'hA; rt_addr = 10; rt_data = 32'hB; imm = 32'h10;
    alu_src = 1; uses_rt = 1; alu_sel = ALU_ADD;
    step();
    push_full("sw_capture", 1, 32'hA, 32'h10, 32'hB, ALU_ADD, 10, 0, 0, 1, 0, 0);
    stall = 1; rs_data = 32'hDEAD; rt_data = 32'hBEEF; alu_sel = ALU_SUB; mem_write = 0;
    reg_write = 1; rd_addr = 20; reg_dst = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      push_full($sformatf("stall_hold%0d", i), 1, 32'hA, 32'h10, 32'hB, ALU_ADD, 10,
                0, 0, 1, 0, 0);
      imm = imm + 1;
    end
    flush = 1;
    step();
    push_full("flush_over_stall", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
    flush = 0; stall = 0;
    step();
    push_full("recapture", 1, 32'hDEAD, 32'h13, 32'hBEEF, ALU_SUB, 20, 1, 0, 0, 0, 0);
    valid = 0;
    step();
    push_full("load_invalid", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);

    // Pending EX/MEM or MEM/WB writes to a decode source.
    valid = 1; rs_addr = 4; rs_data = 32'h40; rt_addr = 0; rt_data = 0; alu_src = 0;
    reg_write = 1; reg_dst = 1; rd_addr = 12; alu_sel = ALU_ADD; uses_rt = 0; mem_write = 0;
    step();
    stall = 1; exm_reg_write = 1; exm_wr_addr = 4; exm_data = 32'h77;
    push_full("haz_exm", 1, FWD ? 32'h77 : 32'h40, 0, 0, ALU_ADD, 12, 1, 0, 0, 0,
              FWD ? 1'b0 : 1'b1);
    step();
    exm_reg_write = 0; wb_reg_write = 1; wb_wr_addr = 4; wb_data = 32'h88;
    rs_addr = 1; rt_addr = 4; uses_rt = 1;
    push_op1("haz_wb_op1", FWD ? 32'h88 : 32'h40);
    push_stall("haz_wb_rt", FWD ? 1'b0 : 1'b1);
    step();
    uses_rt = 0;
    push_stall("haz_wb_rt_unused", 0);
    step();

    // Asynchronous reset between clock edges while a valid ADD is held.
    clr_inputs();
    #1;
    rst_n = 1'b0;
    push_full("async_reset", 0, 0, 0, 0, ALU_ADD, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();

    if (sb.size() != 0) begin
      n_total++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
